// File: rtl/brc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brc_pkg
//  Description : Shared types, default sizes and the ramp-pattern helper for
//                the BRAM readback checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package brc_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } brc_state_e;

  localparam int BRC_ADDR_W      = 10;
  localparam int BRC_DATA_W      = 16;
  localparam int BRC_RD_LAT      = 1;
  localparam int BRC_PATTERN_OFS = 1;

  // Word the ramp-fill writer leaves at an address. Computed at 32 bits; the
  // caller keeps only the low DATA_W bits, so no address-width truncation.
  function automatic logic [31:0] brc_expected(input logic [31:0] addr,
                                               input logic [31:0] ofs);
    return addr + ofs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/brc_lat_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : brc_lat_pipe
//  Description : RD_LAT-deep {valid, addr} delay line that lines issued read
//                addresses up with the BRAM read data. pending_o flags any
//                valid entry that has not yet reached the compare stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module brc_lat_pipe #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              pending_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  // Shift every cycle; reset flushes the line so nothing is compared afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign addr_o  = addr_q[RD_LAT-1];

  // The last stage is being compared this cycle, so only earlier stages count
  generate
    if (RD_LAT > 1) begin : g_pending
      assign pending_o = |valid_q[RD_LAT-2:0];
    end else begin : g_no_pending
      assign pending_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bram_readback_checker.sv
`default_nettype none
// ============================================================================
//  Module      : bram_readback_checker
//  Description : Sweeps BRAM port B once per start and checks every word
//                against the ramp pattern addr + PATTERN_OFS. Reports pass,
//                a saturating mismatch count and the first failing address.
//                Optional macro BRC_STOP_ON_ERR_EN: abort the sweep at the
//                first mismatch (in-flight reads drain uncompared).
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_readback_checker
  import brc_pkg::*;
#(
  parameter int ADDR_W      = BRC_ADDR_W,
  parameter int DATA_W      = BRC_DATA_W,
  parameter int RD_LAT      = BRC_RD_LAT,
  parameter int PATTERN_OFS = BRC_PATTERN_OFS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   ERR_MAX   = '1;
  localparam logic [31:0]       DATA_MASK = 32'hFFFF_FFFF >> (32 - DATA_W);

  brc_state_e        state_q;
  logic [ADDR_W-1:0] addrb_q;
  logic              enb_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W:0]   err_cnt_q;
  logic [ADDR_W:0]   err_cnt_d;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic [ADDR_W-1:0] first_err_addr_d;

  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic              lat_pending;
  logic [31:0]       exp_word;
  logic              cmp_en;
  logic              mismatch;
  logic              stop_req;

  brc_lat_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (enb_q),
    .addr_i    (addrb_q),
    .valid_o   (cmp_valid),
    .addr_o    (cmp_addr),
    .pending_o (lat_pending)
  );

  // Compare the aligned address against doutb and form next result values
  always_comb begin
    exp_word = brc_expected(32'(cmp_addr), 32'(PATTERN_OFS));
`ifdef BRC_STOP_ON_ERR_EN
    // After the first mismatch the remaining reads are drained, not judged
    cmp_en = cmp_valid && (err_cnt_q == '0);
`else
    cmp_en = cmp_valid;
`endif
    mismatch = cmp_en && (((exp_word ^ 32'(doutb)) & DATA_MASK) != 32'd0);
`ifdef BRC_STOP_ON_ERR_EN
    stop_req = mismatch;
`else
    stop_req = 1'b0;
`endif
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    if (mismatch) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0)      first_err_addr_d = cmp_addr;
    end
  end

  // Sweep FSM with registered port-B controls and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      addrb_q          <= '0;
      enb_q            <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
    end else begin
      done_q           <= 1'b0;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q          <= ST_ISSUE;
            addrb_q          <= '0;
            enb_q            <= 1'b1;
            busy_q           <= 1'b1;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
          end
        end
        ST_ISSUE: begin
          if ((addrb_q == LAST_ADDR) || stop_req) begin
            state_q <= ST_DRAIN;
            enb_q   <= 1'b0;
          end else begin
            addrb_q <= addrb_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The final compare lands this cycle, so judge pass on its result
          if (!lat_pending) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign addrb          = addrb_q;
  assign enb            = enb_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;

endmodule
`default_nettype wire
